pb_ram_arbiter: RTL
===================

PB_RAM_ARBITER -- requirements
Module: pb_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, width of the RAM address.
REQ-002 Parameter DATA_W, default 8, width of RAM data.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0, req1  input  1 each  access request from requester 0 and requester 1.
REQ-006 we0, we1  input  1 each  1 = write, 0 = read; qualified by the matching req.
REQ-007 addr0, addr1  input  ADDR_W each  access address.
REQ-008 wdata0, wdata1  input  DATA_W each  write data.
REQ-009 gnt0, gnt1  output  1 each  one-cycle pulse: request accepted and issued to the RAM.
REQ-010 rvalid0, rvalid1  output  1 each  one-cycle pulse: rdata of that requester is valid.
REQ-011 rdata0, rdata1  output  DATA_W each  registered read data.
REQ-012 ram_en, ram_we  output  1 each  RAM enable and write enable.
REQ-013 ram_addr  output  ADDR_W  RAM address.
REQ-014 ram_din  output  DATA_W  RAM write data.
REQ-015 ram_dout  input  DATA_W  RAM read data, valid one cycle after ram_en with ram_we=0.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 gcnt0, gcnt1  output  8 each  grant counters, one per requester.

Function
REQ-018 The FSM SHALL have the states IDLE, ISSUE, WAIT and CAPTURE.
REQ-019 IDLE with any req high SHALL select a winner, latch its we/addr/wdata and go to ISSUE; IDLE with no req SHALL stay in IDLE.
REQ-020 Arbitration SHALL be round-robin: pointer rr names the preferred requester; a lone requester always wins; with both requesting, requester rr wins.
REQ-021 After each grant, rr SHALL point to the requester that did not win.
REQ-022 ISSUE SHALL last exactly one cycle, driving ram_en=1, ram_we, ram_addr and ram_din from the latched values, and pulsing the winner's gnt.
REQ-023 Outside ISSUE, ram_en and ram_we SHALL be 0; ram_addr and ram_din SHALL hold their last values.
REQ-024 From ISSUE, a write SHALL return to IDLE.
REQ-025 From ISSUE, a read SHALL go to WAIT, then to CAPTURE.
REQ-026 In CAPTURE, ram_dout SHALL be loaded into the winner's rdata, the winner's rvalid SHALL be pulsed, and the FSM SHALL return to IDLE.
REQ-027 Latency, req sampled at edge t: gnt and ram_en high in cycle t+1; write complete at t+1; rvalid in cycle t+3.
REQ-028 Requester protocol: req, we, addr and wdata are held stable until gnt is seen; req deasserted before gnt is a legal withdrawal, and only the next IDLE sample counts.
REQ-029 Throughput: one write per 2 cycles and one read per 4 cycles, since requests are sampled only in IDLE.
REQ-030 rdataN SHALL hold its value until that requester's next CAPTURE; the other requester's rdata SHALL be unaffected.
REQ-031 gcntN SHALL increment by 1 on each gntN and wrap from 0xFF to 0x00.
REQ-032 At most one of gnt0/gnt1 SHALL be high in any cycle; the same holds for rvalid0/rvalid1.

Reset
REQ-033 While reset is high, asynchronously: state=IDLE, rr=0, and all outputs 0 (ram_en, ram_we, ram_addr, ram_din, gnt*, rvalid*, rdata*, gcnt*, busy).
REQ-034 Reset asserted mid-operation SHALL abort the access: no further ram_en, gnt or rvalid for it; no pending transfer is resumed after release.
REQ-035 The first IDLE sample SHALL occur on the first rising edge after reset deasserts.

Verification
REQ-036 req0=1, we0=1, addr0=0x10, wdata0=0xA5 -> gnt0 and ram_en/ram_we at t+1 with ram_addr=0x10 and ram_din=0xA5; gcnt0=1.
REQ-037 With 0x10 holding 0xA5, req1=1, we1=0, addr1=0x10 -> gnt1 at t+1, rvalid1 at t+3 with rdata1=0xA5; rdata0 unchanged.
REQ-038 req0 and req1 both held high for 8 grants after reset -> grant order 0,1,0,1,...; gcnt0=gcnt1=4.
REQ-039 Reset pulsed in WAIT of a read -> no rvalid; all outputs 0; busy=0; rr=0.
REQ-040 Requester 0 granted 256 writes -> gcnt0 wraps to 0x00; gcnt1 stays 0.
REQ-041 Every cycle of every test -> never gnt0 and gnt1 both high, never rvalid0 and rvalid1 both high, and ram_en never high outside ISSUE.

Source files
------------

// File: rtl/pb_ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// Each access is fully serialized: writes take IDLE+ISSUE, reads IDLE+ISSUE+WAIT+CAPTURE.
module pb_ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic [7:0]        gcnt0,
  output logic [7:0]        gcnt1
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

  state_t            state_q, state_d;
  logic              rr_q;
  logic              sel_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              win;
  logic              any_req;

  assign any_req = req0 | req1;
  // With both requesting the pointer decides; otherwise the lone requester wins.
  assign win     = (req0 && req1) ? rr_q : req1;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = we_q ? IDLE : WAIT;
      WAIT:    state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata0  <= '0;
      rdata1  <= '0;
      gcnt0   <= 8'd0;
      gcnt1   <= 8'd0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) begin
        sel_q   <= win;
        rr_q    <= ~win;
        we_q    <= win ? we1    : we0;
        addr_q  <= win ? addr1  : addr0;
        wdata_q <= win ? wdata1 : wdata0;
      end
      if (state_q == ISSUE) begin
        if (sel_q) gcnt1 <= gcnt1 + 8'd1;
        else       gcnt0 <= gcnt0 + 8'd1;
      end
      // RAM output is valid during WAIT; capture it so rdata is ready with rvalid.
      if (state_q == WAIT) begin
        if (sel_q) rdata1 <= ram_dout;
        else       rdata0 <= ram_dout;
      end
    end
  end

  // The latched address/data only change on a new grant, so they hold outside ISSUE.
  assign ram_addr = addr_q;
  assign ram_din  = wdata_q;
  assign ram_en   = (state_q == ISSUE);
  assign ram_we   = (state_q == ISSUE) && we_q;
  assign gnt0     = (state_q == ISSUE) && !sel_q;
  assign gnt1     = (state_q == ISSUE) &&  sel_q;
  assign rvalid0  = (state_q == CAPTURE) && !sel_q;
  assign rvalid1  = (state_q == CAPTURE) &&  sel_q;
  assign busy     = (state_q != IDLE);

endmodule
